uart_cmd_sched: RTL and testbench

Command scheduler that shares the single byte-wide UART transmitter between `N_REQ` command sources. Each source presents a 12-byte command buffer plus a length. The block arbitrates round-robin, latches the granted buffer and streams its bytes to the UART TX over a valid/ready handshake. It replaces direct `uart_start`/`cmd_buf` wiring between one source and the UART.

---
 rtl/uart_cmd_sched_pkg.sv | 32 +++
 rtl/uart_cmd_sched_if.sv | 27 ++
 rtl/uart_cmd_sched_arb.sv | 65 ++++++
 rtl/uart_cmd_sched.sv | 201 ++++++++++++++++++++
 tb/tb_uart_cmd_sched.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_sched_pkg.sv
// -----------------------------------------------------------------------------
// uart_cmd_pkg
// Shared types and helpers for the UART command scheduler.
//   CMD_BYTES_DEF : default number of bytes in a command buffer
//   cmd_buf_t     : one command buffer at the default size, byte 0 sent first
//   sched_state_e : scheduler FSM states
//   clamp_len()   : maps a requested length onto 1..max_bytes
// Optional feature macro used by the scheduler: UART_CMD_CHECKSUM_EN.
// -----------------------------------------------------------------------------
package uart_cmd_pkg;

   localparam int CMD_BYTES_DEF = 12;

   typedef logic [CMD_BYTES_DEF-1:0][7:0] cmd_buf_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      CSUM = 2'd2,
      DONE = 2'd3
   } sched_state_e;

   // A zero length or one longer than the buffer means "send the whole buffer".
   function automatic logic [3:0] clamp_len(input logic [3:0] len,
                                            input int unsigned max_bytes);
      if ((len == 4'd0) || (32'(len) > max_bytes)) begin
         return 4'(max_bytes);
      end
      return len;
   endfunction

endpackage

// File: rtl/uart_cmd_sched_if.sv
// -----------------------------------------------------------------------------
// uart_cmd_sched_if
// Byte-wide valid/ready stream from the scheduler into the UART transmitter.
//   tx_data  : byte presented to the UART
//   tx_valid : tx_data holds a byte to send
//   tx_ready : UART accepts the byte in this cycle
// Modports: master (scheduler side), slave (UART side).
// -----------------------------------------------------------------------------
interface uart_cmd_sched_if;

   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready
   );

endinterface

// File: rtl/uart_cmd_sched_arb.sv
// -----------------------------------------------------------------------------
// uart_rr_arbiter
// Round-robin arbiter. Priority starts one past the last granted source and
// wraps; after reset the last grant is N_REQ-1 so source 0 wins first.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   req        : per-source request
//   en         : commit the current grant as the new last_grant
//   grant      : one-hot grant (all zero when no request)
//   grant_idx  : encoded grant, only meaningful when |req
// -----------------------------------------------------------------------------
module uart_rr_arbiter #(
   parameter  int N_REQ = 2,
   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic             en,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] grant_idx
);

   logic [IDX_W-1:0] last_grant_q;
   logic [IDX_W-1:0] last_grant_d;
   logic [IDX_W-1:0] pick;
   logic             any_req;

   // Scan from last_grant+1 upward; the first requester found wins.
   always_comb begin
      int cand;
      pick    = last_grant_q;
      any_req = 1'b0;
      cand    = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = (int'(last_grant_q) + k) % N_REQ;
         if (!any_req && req[cand]) begin
            any_req = 1'b1;
            pick    = IDX_W'(cand);
         end
      end
   end

   always_comb begin
      last_grant_d = last_grant_q;
      if (en && any_req) begin
         last_grant_d = pick;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q <= IDX_W'(N_REQ - 1);
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_grant
      assign grant[gi] = any_req && (pick == IDX_W'(gi));
   end

   assign grant_idx = pick;

endmodule

// File: rtl/uart_cmd_sched.sv
// -----------------------------------------------------------------------------
// uart_cmd_sched
// Shares one byte-wide UART transmitter between N_REQ command sources.
// A granted source's buffer and clamped length are copied into a shadow
// register, then streamed byte by byte over the tx valid/ready interface.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   req       : per-source request, held until ack
//   cmd_buf   : per-source command bytes, byte 0 sent first
//   cmd_len   : per-source length (0 or > CMD_BYTES means CMD_BYTES)
//   ack       : one-cycle pulse, source buffer latched
//   done      : one-cycle pulse, command fully accepted by the UART
//   busy      : scheduler not idle
//   tx        : byte stream to the UART (master modport)
// Optional feature: define UART_CMD_CHECKSUM_EN to append an XOR checksum
// byte after every command.
// -----------------------------------------------------------------------------
module uart_cmd_sched
   import uart_cmd_pkg::*;
#(
   parameter  int N_REQ     = 2,
   parameter  int CMD_BYTES = CMD_BYTES_DEF,
   localparam int IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [N_REQ-1:0]                  req,
   input  logic [N_REQ-1:0][CMD_BYTES-1:0][7:0] cmd_buf,
   input  logic [N_REQ-1:0][3:0]             cmd_len,
   output logic [N_REQ-1:0]                  ack,
   output logic [N_REQ-1:0]                  done,
   output logic                              busy,
   uart_cmd_sched_if.master                  tx
);

   sched_state_e                 state_q, state_d;
   logic [CMD_BYTES-1:0][7:0]    shadow_q, shadow_d;
   logic [3:0]                   byte_idx_q, byte_idx_d;
   logic [3:0]                   last_idx_q, last_idx_d;
   logic [IDX_W-1:0]             grant_idx_q, grant_idx_d;
   logic [N_REQ-1:0]             ack_q, ack_d;
`ifdef UART_CMD_CHECKSUM_EN
   logic [7:0]                   csum_q, csum_d;
`endif

   logic [N_REQ-1:0] arb_grant;
   logic [IDX_W-1:0] arb_idx;
   logic             arb_en;

   logic [N_REQ-1:0] done_hot;
   logic [N_REQ-1:0] done_o;
   logic [7:0]       tx_data_o;
   logic             tx_valid_o;
   logic             busy_o;
   logic             tx_fire;

   // Arbitration only commits while idle, so requests seen mid-transfer
   // neither get granted nor move the round-robin pointer.
   assign arb_en = (state_q == IDLE);

   uart_rr_arbiter #(
      .N_REQ (N_REQ)
   ) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .en        (arb_en),
      .grant     (arb_grant),
      .grant_idx (arb_idx)
   );

   assign tx_fire = tx_valid_o && tx.tx_ready;

   // ---------------------------------------------------------------------
   // State register (FSM state plus the datapath it sequences)
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         shadow_q    <= '0;
         byte_idx_q  <= 4'd0;
         last_idx_q  <= 4'd0;
         grant_idx_q <= '0;
         ack_q       <= '0;
`ifdef UART_CMD_CHECKSUM_EN
         csum_q      <= 8'h00;
`endif
      end else begin
         state_q     <= state_d;
         shadow_q    <= shadow_d;
         byte_idx_q  <= byte_idx_d;
         last_idx_q  <= last_idx_d;
         grant_idx_q <= grant_idx_d;
         ack_q       <= ack_d;
`ifdef UART_CMD_CHECKSUM_EN
         csum_q      <= csum_d;
`endif
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      shadow_d    = shadow_q;
      byte_idx_d  = byte_idx_q;
      last_idx_d  = last_idx_q;
      grant_idx_d = grant_idx_q;
      ack_d       = '0;
`ifdef UART_CMD_CHECKSUM_EN
      csum_d      = csum_q;
`endif
      case (state_q)
         IDLE: begin
            if (|req) begin
               state_d     = SEND;
               shadow_d    = cmd_buf[arb_idx];
               last_idx_d  = clamp_len(cmd_len[arb_idx], CMD_BYTES) - 4'd1;
               grant_idx_d = arb_idx;
               byte_idx_d  = 4'd0;
               ack_d       = arb_grant;
`ifdef UART_CMD_CHECKSUM_EN
               csum_d      = 8'h00;
`endif
            end
         end
         SEND: begin
            if (tx_fire) begin
`ifdef UART_CMD_CHECKSUM_EN
               csum_d = csum_q ^ shadow_q[byte_idx_q];
`endif
               // The index stops on the last byte so it never walks past
               // the end of the buffer.
               if (byte_idx_q == last_idx_q) begin
`ifdef UART_CMD_CHECKSUM_EN
                  state_d = CSUM;
`else
                  state_d = DONE;
`endif
               end else begin
                  byte_idx_d = byte_idx_q + 4'd1;
               end
            end
         end
`ifdef UART_CMD_CHECKSUM_EN
         CSUM: begin
            if (tx_fire) begin
               state_d = DONE;
            end
         end
`endif
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Output logic (all outputs decode registered state, so tx_data and
   // tx_valid cannot move while the UART stalls)
   // ---------------------------------------------------------------------
   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_done
      assign done_hot[gi] = (grant_idx_q == IDX_W'(gi));
   end

   always_comb begin
      busy_o     = (state_q != IDLE);
      tx_valid_o = 1'b0;
      tx_data_o  = 8'h00;
      done_o     = '0;
      case (state_q)
         SEND: begin
            tx_valid_o = 1'b1;
            tx_data_o  = shadow_q[byte_idx_q];
         end
`ifdef UART_CMD_CHECKSUM_EN
         CSUM: begin
            tx_valid_o = 1'b1;
            tx_data_o  = csum_q;
         end
`endif
         DONE: begin
            done_o = done_hot;
         end
         default: begin
            done_o = '0;
         end
      endcase
   end

   assign ack         = ack_q;
   assign done        = done_o;
   assign busy        = busy_o;
   assign tx.tx_data  = tx_data_o;
   assign tx.tx_valid = tx_valid_o;

endmodule

// File: tb/tb_uart_cmd_sched.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_sched
// Self-checking bench for uart_cmd_sched. Commands are issued in rounds; a
// reference model predicts the round-robin service order and the byte stream
// of every command from its buffer and length.
// -----------------------------------------------------------------------------
module tb_uart_cmd_sched;
   import uart_cmd_pkg::*;

   localparam int N  = 2;
   localparam int CB = CMD_BYTES_DEF;

   logic                     clk = 1'b0;
   logic                     rst;
   logic [N-1:0]             req;
   logic [N-1:0][CB-1:0][7:0] cmd_buf;
   logic [N-1:0][3:0]        cmd_len;
   logic [N-1:0]             ack;
   logic [N-1:0]             done;
   logic                     busy;

   uart_cmd_sched_if tx_if ();

   uart_cmd_sched #(
      .N_REQ     (N),
      .CMD_BYTES (CB)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .cmd_buf (cmd_buf),
      .cmd_len (cmd_len),
      .ack     (ack),
      .done    (done),
      .busy    (busy),
      .tx      (tx_if)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int model_ptr;                 // last granted source in the model
   logic [7:0] exp_bytes[N][$];   // expected byte stream per source

   task automatic chk_val(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Expected stream: the first L bytes, plus their XOR when checksum is on.
   task automatic fill_exp(input int s);
      int L;
      logic [7:0] x;
      exp_bytes[s].delete();
      L = ((cmd_len[s] == 4'd0) || (int'(cmd_len[s]) > CB)) ? CB : int'(cmd_len[s]);
      x = 8'h00;
      for (int i = 0; i < L; i++) begin
         exp_bytes[s].push_back(cmd_buf[s][i]);
         x = x ^ cmd_buf[s][i];
      end
`ifdef UART_CMD_CHECKSUM_EN
      exp_bytes[s].push_back(x);
`endif
   endtask

   function automatic logic ready_for(input int mode, input int c);
      if (mode == 0) return 1'b1;
      if (mode == 1) return (c % 3) == 0;
      return $urandom_range(0, 3) != 0;
   endfunction

   // One round: all sources in mask request together from IDLE.
   task automatic run_round(input logic [N-1:0] mask, input int ready_mode,
                            input int force_len, input bit keep_buf);
      int         order[$];
      int         n_cmd, acked, dones, cur, ack_cyc, stall_err, s, nb;
      logic [7:0] got[$];
      logic       hold;
      logic [7:0] hold_data;
      bit         fin;
      for (int k = 1; k <= N; k++) begin
         s = (model_ptr + k) % N;
         if (mask[s]) order.push_back(s);
      end
      n_cmd = order.size();
      model_ptr = order[n_cmd-1];
      for (int i = 0; i < N; i++) begin
         if (mask[i]) begin
            if (!keep_buf) begin
               for (int b = 0; b < CB; b++) cmd_buf[i][b] = 8'($urandom);
            end
            cmd_len[i] = (force_len >= 0) ? 4'(force_len) : 4'($urandom_range(0, 15));
            fill_exp(i);
         end
      end
      @(negedge clk);
      req = mask;
      cur = -1; acked = 0; dones = 0; ack_cyc = 0; stall_err = 0;
      hold = 1'b0; hold_data = 8'h00; fin = 1'b0;
      for (int cyc = 0; cyc < 1000 && !fin; cyc++) begin
         @(negedge clk);
         if (hold && (tx_if.tx_valid !== 1'b1 || tx_if.tx_data !== hold_data)) stall_err++;
         tx_if.tx_ready = ready_for(ready_mode, cyc);
         if (ack !== '0) begin
            if (acked < n_cmd) begin
               chk_val("ack_src", 32'(ack), 32'(1) << order[acked]);
               cur = order[acked];
            end else begin
               chk_val("ack_extra", 32'(ack), 32'd0);
            end
            if (ready_mode == 0 && acked == 0) chk_val("ack_lat", 32'(cyc), 32'd0);
            chk_val("busy_at_ack", 32'(busy), 32'd1);
            if (cur >= 0) begin
               req[cur] = 1'b0;
               // Scramble the source buffer: only the shadow copy may be sent.
               for (int b = 0; b < CB; b++) cmd_buf[cur][b] = 8'($urandom);
            end
            ack_cyc = cyc;
            got.delete();
            acked++;
         end
         if (tx_if.tx_valid === 1'b1 && tx_if.tx_ready) got.push_back(tx_if.tx_data);
         hold      = (tx_if.tx_valid === 1'b1) && !tx_if.tx_ready;
         hold_data = tx_if.tx_data;
         if (done !== '0) begin
            if (cur < 0) begin
               chk_val("done_unexp", 32'(done), 32'd0);
            end else begin
               chk_val("done_src", 32'(done), 32'(1) << cur);
               chk_val("nbytes", 32'(got.size()), 32'(exp_bytes[cur].size()));
               nb = (got.size() < exp_bytes[cur].size()) ? got.size() : exp_bytes[cur].size();
               for (int i = 0; i < nb; i++) begin
                  chk_val($sformatf("byte%0d_src%0d", i, cur), 32'(got[i]), 32'(exp_bytes[cur][i]));
               end
               if (ready_mode == 0) begin
                  chk_val("done_lat", 32'(cyc - ack_cyc), 32'(exp_bytes[cur].size()));
               end
               $display("cmd src=%0d len=%0d bytes=%0d ready_mode=%0d",
                        cur, cmd_len[cur], got.size(), ready_mode);
            end
            dones++;
         end
         if (dones >= n_cmd && !busy) fin = 1'b1;
      end
      chk_val("round_done_cnt", 32'(dones), 32'(n_cmd));
      chk_val("stall_hold", 32'(stall_err), 32'd0);
      req = '0;
   endtask

   // Reset after byte 2 is accepted: the transfer must vanish without done.
   task automatic abort_test();
      int fires;
      fires = 0;
      for (int b = 0; b < CB; b++) cmd_buf[0][b] = 8'($urandom);
      cmd_len[0] = 4'd8;
      @(negedge clk);
      req = 2'b01;
      tx_if.tx_ready = 1'b1;
      for (int cyc = 0; cyc < 50 && fires < 3; cyc++) begin
         @(negedge clk);
         if (ack[0]) req[0] = 1'b0;
         if (tx_if.tx_valid === 1'b1 && tx_if.tx_ready) fires++;
      end
      chk_val("abort_reached", 32'(fires), 32'd3);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_val("abort_valid", 32'(tx_if.tx_valid), 32'd0);
      chk_val("abort_done", 32'(done), 32'd0);
      rst = 1'b0;
      model_ptr = N - 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk_val("abort_idle", {29'd0, busy, done}, 32'd0);
      end
      $display("abort after byte 2 complete");
      run_round(2'b10, 0, -1, 0);
   endtask

   initial begin
      rst            = 1'b1;
      req            = '0;
      cmd_buf        = '0;
      cmd_len        = '0;
      tx_if.tx_ready = 1'b0;
      model_ptr      = N - 1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk_val("idle_out", {19'd0, ack, done, busy, tx_if.tx_valid, tx_if.tx_data}, 32'd0);
      end
      $display("reset/idle window complete");

      // Single known command.
      cmd_buf[0][0] = 8'h14;
      cmd_buf[0][1] = 8'h00;
      cmd_buf[0][2] = 8'h00;
      cmd_buf[0][3] = 8'h01;
      cmd_buf[0][4] = 8'h98;
      run_round(2'b01, 0, 5, 1);

      // Backpressure with a 1,0,0 ready pattern.
      run_round(2'b01, 1, -1, 0);
      run_round(2'b11, 1, -1, 0);

      // Contention, repeated, then a lone request from source 1.
      run_round(2'b11, 0, 2, 0);
      run_round(2'b11, 0, 2, 0);
      run_round(2'b10, 0, 2, 0);

      // Length clamp.
      run_round(2'b01, 0, 0, 0);
      run_round(2'b01, 0, 15, 0);

      abort_test();

      for (int r = 0; r < 20; r++) begin
         run_round(2'($urandom_range(1, 3)), $urandom_range(0, 2), -1, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
